// File: rtl/queen_board_checker_pkg.sv
// Shared constants and state encoding for the eight-queens board checker.
package queen_board_checker_pkg;

  localparam int unsigned BOARD_SIZE = 8;
  localparam int unsigned ROW_W      = 3;
  localparam int unsigned DIFF_W     = 6;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    REPORT  = 2'd2
  } state_e;

endpackage

// File: rtl/queen_board_checker_if.sv
// Row-word stream in, verdict handshake out; master is the solver/consumer side.
interface queen_board_checker_if;
  import queen_board_checker_pkg::*;

  logic                  in_valid;
  logic [BOARD_SIZE-1:0] in_data;
  logic                  in_ready;
  logic                  result_valid;
  logic                  result_ack;
  logic                  board_ok;
  logic [ROW_W-1:0]      fail_row_a;
  logic [ROW_W-1:0]      fail_row_b;

  modport master (
    output in_valid, in_data, result_ack,
    input  in_ready, result_valid, board_ok, fail_row_a, fail_row_b
  );

  modport slave (
    input  in_valid, in_data, result_ack,
    output in_ready, result_valid, board_ok, fail_row_a, fail_row_b
  );

endinterface

// File: rtl/onehot_to_index.sv
// Combinational one-hot to binary index; o_valid is set only for exactly one bit.
module onehot_to_index
  import queen_board_checker_pkg::*;
#(
  parameter int unsigned WIDTH = BOARD_SIZE
) (
  input  logic [WIDTH-1:0] i_onehot,
  output logic [ROW_W-1:0] o_index,
  output logic             o_valid
);

  always_comb begin
    o_index = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (i_onehot[k]) o_index = o_index | ROW_W'(k);
    end
  end

  // x & (x-1) clears the lowest set bit, so zero means at most one bit was set
  assign o_valid = (i_onehot != '0) && ((i_onehot & (i_onehot - WIDTH'(1))) == '0);

endmodule

// File: rtl/queen_board_checker.sv
// Collects one queen column per row, then walks every row pair for column/diagonal attacks.
module queen_board_checker
  import queen_board_checker_pkg::*;
#(
  parameter int unsigned BOARD_SIZE = queen_board_checker_pkg::BOARD_SIZE
) (
  input  logic                        clk,
  input  logic                        reset,
  queen_board_checker_if.slave        bus
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BOARD_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_PEN  = ROW_W'(BOARD_SIZE - 2);

  state_e           r_state, w_state_nxt;
  logic             r_in_ready, w_in_ready_nxt;
  logic             r_result_valid, w_result_valid_nxt;
  logic             r_board_ok, w_board_ok_nxt;
  logic [ROW_W-1:0] r_fail_a, w_fail_a_nxt;
  logic [ROW_W-1:0] r_fail_b, w_fail_b_nxt;
  logic [ROW_W-1:0] r_i, w_i_nxt;
  logic [ROW_W-1:0] r_j, w_j_nxt;

  logic [ROW_W-1:0] r_row_cnt;
  logic             r_full;
  logic [ROW_W-1:0] r_cols [BOARD_SIZE];
  logic             r_bad_enc;
  logic [ROW_W-1:0] r_bad_row;

  logic             w_xfer;
  logic             w_last_xfer;
  logic [ROW_W-1:0] w_col;
  logic             w_enc_ok;
  logic [DIFF_W-1:0] w_ci, w_cj, w_diff, w_dist;
  logic             w_conflict;

  onehot_to_index #(.WIDTH(BOARD_SIZE)) u_enc (
    .i_onehot (bus.in_data),
    .o_index  (w_col),
    .o_valid  (w_enc_ok)
  );

  assign w_xfer      = bus.in_valid & r_in_ready;
  assign w_last_xfer = w_xfer && (r_row_cnt == ROW_LAST);

  // Pair test on zero-extended columns so the absolute difference never wraps
  assign w_ci       = DIFF_W'(r_cols[r_i]);
  assign w_cj       = DIFF_W'(r_cols[r_j]);
  assign w_diff     = (w_ci >= w_cj) ? (w_ci - w_cj) : (w_cj - w_ci);
  assign w_dist     = DIFF_W'(r_j) - DIFF_W'(r_i);
  assign w_conflict = (w_diff == '0) || (w_diff == w_dist);

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= COLLECT;
      r_in_ready     <= 1'b1;
      r_result_valid <= 1'b0;
      r_board_ok     <= 1'b0;
      r_fail_a       <= '0;
      r_fail_b       <= '0;
      r_i            <= '0;
      r_j            <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_in_ready     <= w_in_ready_nxt;
      r_result_valid <= w_result_valid_nxt;
      r_board_ok     <= w_board_ok_nxt;
      r_fail_a       <= w_fail_a_nxt;
      r_fail_b       <= w_fail_b_nxt;
      r_i            <= w_i_nxt;
      r_j            <= w_j_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_board_ok_nxt = r_board_ok;
    w_fail_a_nxt = r_fail_a;
    w_fail_b_nxt = r_fail_b;
    w_i_nxt      = r_i;
    w_j_nxt      = r_j;

    unique case (r_state)
      COLLECT: begin
        if (r_full) begin
          w_state_nxt = CHECK;
          w_i_nxt     = '0;
          w_j_nxt     = ROW_W'(1);
        end
      end
      CHECK: begin
        if (r_bad_enc) begin
          w_state_nxt    = REPORT;
          w_board_ok_nxt = 1'b0;
          w_fail_a_nxt   = r_bad_row;
          w_fail_b_nxt   = r_bad_row;
        end else if (w_conflict) begin
          w_state_nxt    = REPORT;
          w_board_ok_nxt = 1'b0;
          w_fail_a_nxt   = r_i;
          w_fail_b_nxt   = r_j;
        end else if ((r_i == ROW_PEN) && (r_j == ROW_LAST)) begin
          w_state_nxt    = REPORT;
          w_board_ok_nxt = 1'b1;
          w_fail_a_nxt   = '0;
          w_fail_b_nxt   = '0;
        end else if (r_j == ROW_LAST) begin
          w_i_nxt = r_i + ROW_W'(1);
          w_j_nxt = r_i + ROW_W'(2);
        end else begin
          w_j_nxt = r_j + ROW_W'(1);
        end
      end
      REPORT: begin
        if (bus.result_ack) begin
          w_state_nxt    = COLLECT;
          w_board_ok_nxt = 1'b0;
          w_fail_a_nxt   = '0;
          w_fail_b_nxt   = '0;
          w_i_nxt        = '0;
          w_j_nxt        = '0;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase

    // Ready drops for the drain cycle after the last row so no word of the next board slips in
    w_in_ready_nxt     = (w_state_nxt == COLLECT) && !w_last_xfer;
    w_result_valid_nxt = (w_state_nxt == REPORT);
  end

  // Column storage, row counter and sticky encoding error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_row_cnt <= '0;
      r_full    <= 1'b0;
      r_bad_enc <= 1'b0;
      r_bad_row <= '0;
      for (int k = 0; k < BOARD_SIZE; k++) r_cols[k] <= '0;
    end else begin
      r_full <= w_last_xfer;
      if (w_xfer) begin
        r_cols[r_row_cnt] <= w_col;
        r_row_cnt         <= r_row_cnt + ROW_W'(1);
        if (!w_enc_ok && !r_bad_enc) begin
          r_bad_enc <= 1'b1;
          r_bad_row <= r_row_cnt;
        end
      end else if ((r_state == REPORT) && bus.result_ack) begin
        r_bad_enc <= 1'b0;
        r_bad_row <= '0;
      end
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.result_valid = r_result_valid;
  assign bus.board_ok     = r_board_ok;
  assign bus.fail_row_a   = r_fail_a;
  assign bus.fail_row_b   = r_fail_b;

endmodule
